// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared fetch FSM encoding, reset PC default and NOP constant
package mips_pipe_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetchState_e;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction
endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: holds an acked instruction word while the pipeline is stalled
module fetch_skid_reg (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iLoad,
  input  logic        iDrop,
  input  logic [31:0] iData,
  output logic [31:0] oData
);
  // capture on load, clear once the word is consumed or squashed
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) oData <= '0;
    else if (iLoad) oData <= iData;
    else if (iDrop) oData <= '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM, PC and IF/ID register; FETCH_STALLCNT_EN enables the stall counter
module fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iBlockPC,
  input  logic        iBlockIFID,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic [31:0] oIFID_Instr,
  output logic [31:0] oIFID_PC4,
  output logic        oIFID_Valid,
  output logic [31:0] oStallCount
);
  fetchState_e state, stateNext;
  logic [31:0] pc, pcNext, tgt, tgtNext, instr, instrNext, pc4, pc4Next;
  logic [31:0] skidData, redirPC, pcPlus4;
  logic valid, validNext, skidLoad, skidDrop;

  assign redirPC = wordAlign(iRedirectPC);
  assign pcPlus4 = pc + 32'd4;

  fetch_skid_reg skid (
    .iCLK(iCLK),
    .iRST(iRST),
    .iLoad(skidLoad),
    .iDrop(skidDrop),
    .iData(iIMemData),
    .oData(skidData)
  );

  // state register
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) state <= IDLE;
    else state <= stateNext;

  // next state, PC/target/IF-ID next values and skid control; redirect wins over blocks
  always_comb begin
    stateNext = state;
    pcNext = pc;
    tgtNext = tgt;
    instrNext = instr;
    pc4Next = pc4;
    validNext = valid;
    skidLoad = 1'b0;
    skidDrop = 1'b0;
    unique case (state)
      IDLE: stateNext = FETCH;
      FETCH:
        if (iRedirect) begin
          validNext = 1'b0;
          instrNext = NOP;
          if (iIMemAck) pcNext = redirPC;
          else begin
            tgtNext = redirPC;
            stateNext = DISCARD;
          end
        end else if (iIMemAck) begin
          if (iBlockPC || iBlockIFID) begin
            skidLoad = 1'b1;
            stateNext = HOLD;
          end else begin
            instrNext = iIMemData;
            pc4Next = pcPlus4;
            validNext = 1'b1;
            pcNext = pcPlus4;
          end
        end
      HOLD:
        if (iRedirect) begin
          skidDrop = 1'b1;
          pcNext = redirPC;
          validNext = 1'b0;
          instrNext = NOP;
          stateNext = FETCH;
        end else if (!iBlockPC && !iBlockIFID) begin
          skidDrop = 1'b1;
          instrNext = skidData;
          pc4Next = pcPlus4;
          validNext = 1'b1;
          pcNext = pcPlus4;
          stateNext = FETCH;
        end
      DISCARD:
        if (iRedirect) begin
          tgtNext = redirPC;
          validNext = 1'b0;
          instrNext = NOP;
          if (iIMemAck) begin
            pcNext = redirPC;
            stateNext = FETCH;
          end
        end else if (iIMemAck) begin
          pcNext = tgt;
          stateNext = FETCH;
        end
    endcase
  end

  // PC, latched redirect target and IF/ID registers
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      pc <= RESET_PC;
      tgt <= '0;
      instr <= NOP;
      pc4 <= '0;
      valid <= 1'b0;
    end else begin
      pc <= pcNext;
      tgt <= tgtNext;
      instr <= instrNext;
      pc4 <= pc4Next;
      valid <= validNext;
    end

  assign oIMemReq = (state == FETCH) || (state == DISCARD);
  assign oIMemAddr = pc;
  assign oIFID_Instr = instr;
  assign oIFID_PC4 = pc4;
  assign oIFID_Valid = valid;

`ifdef FETCH_STALLCNT_EN
  logic [31:0] stallCnt;
  logic stallEv;
  assign stallEv = (state == HOLD) || (state == DISCARD) || ((state == FETCH) && !iIMemAck) || iBlockIFID;

  // saturating count of cycles in which fetch makes no forward progress
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) stallCnt <= '0;
    else if (stallEv && stallCnt != '1) stallCnt <= stallCnt + 32'd1;

  assign oStallCount = stallCnt;
`else
  assign oStallCount = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic iCLK = 1'b0;
  logic iRST, iBlockPC, iBlockIFID, iRedirect, iIMemAck;
  logic [31:0] iRedirectPC, iIMemData;
  logic oIMemReq, oIFID_Valid;
  logic [31:0] oIMemAddr, oIFID_Instr, oIFID_PC4, oStallCount;

  always #5 iCLK = ~iCLK;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iBlockPC(iBlockPC),
    .iBlockIFID(iBlockIFID),
    .iRedirect(iRedirect),
    .iRedirectPC(iRedirectPC),
    .oIMemReq(oIMemReq),
    .oIMemAddr(oIMemAddr),
    .iIMemAck(iIMemAck),
    .iIMemData(iIMemData),
    .oIFID_Instr(oIFID_Instr),
    .oIFID_PC4(oIFID_PC4),
    .oIFID_Valid(oIFID_Valid),
    .oStallCount(oStallCount)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  int vectors = 0;
  int miscompares = 0;
  ifid_t expQ[$];

  logic [31:0] archPC = RST_PC;
  logic [31:0] stallExp = '0;
  bit mIdle = 1'b1;
  bit mHeld = 1'b0;
  bit mDiscard = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // architectural model: next fetch address, held/discard flags, expected delivered words
  task automatic modelStep();
    bit reqExp;
    reqExp = !mIdle && !mHeld;
    if (iRST) begin
      expQ.delete();
      archPC = RST_PC;
      mIdle = 1'b1;
      mHeld = 1'b0;
      mDiscard = 1'b0;
      stallExp = '0;
      return;
    end
    chk("imem_req", {31'b0, oIMemReq}, {31'b0, reqExp});
    if (reqExp && !mDiscard) chk("imem_addr", oIMemAddr, archPC);
`ifdef FETCH_STALLCNT_EN
    chk("stall_count", oStallCount, stallExp);
    if ((mHeld || mDiscard || (reqExp && !iIMemAck) || iBlockIFID) && stallExp != '1) stallExp++;
`else
    chk("stall_count", oStallCount, 32'd0);
`endif
    if (mIdle) begin
      mIdle = 1'b0;
      return;
    end
    if (iRedirect) begin
      expQ.delete();
      archPC = iRedirectPC & ~32'h3;
      mDiscard = reqExp && !iIMemAck;
      mHeld = 1'b0;
    end else if (mHeld) begin
      if (!iBlockPC && !iBlockIFID) mHeld = 1'b0;
    end else if (iIMemAck) begin
      if (mDiscard) mDiscard = 1'b0;
      else begin
        expQ.push_back({iIMemData, archPC + 32'd4});
        archPC = archPC + 32'd4;
        mHeld = iBlockPC || iBlockIFID;
      end
    end
  endtask

  task automatic cyc(input bit ack, input bit bpc, input bit bif, input bit rd,
                     input logic [31:0] tgt, input logic [31:0] data, input bit rst = 1'b0);
    iIMemAck = ack;
    iBlockPC = bpc;
    iBlockIFID = bif;
    iRedirect = rd;
    iRedirectPC = tgt;
    iIMemData = data;
    iRST = rst;
    @(negedge iCLK);
    #1;
    modelStep();
    @(posedge iCLK);
    #1;
  endtask

  // monitor: compares IF/ID against the scoreboard whenever a new word appears
  ifid_t expIf = '0;
  bit expValid = 1'b0;
  bit prevRedir = 1'b0;
  bit prevBlk = 1'b0;
  always @(negedge iCLK) begin
    if (iRST) begin
      expValid = 1'b0;
      prevRedir = 1'b0;
      prevBlk = 1'b0;
    end else begin
      if (prevRedir) begin
        chk("ifid_squash_valid", {31'b0, oIFID_Valid}, 32'd0);
        chk("ifid_squash_instr", oIFID_Instr, 32'd0);
        expValid = 1'b0;
      end else if (!prevBlk && oIFID_Valid && (!expValid || oIFID_PC4 != expIf.pc4)) begin
        if (expQ.size() == 0) chk("ifid_unexpected", {31'b0, oIFID_Valid}, 32'd0);
        else begin
          expIf = expQ.pop_front();
          expValid = 1'b1;
          chk("ifid_instr", oIFID_Instr, expIf.instr);
          chk("ifid_pc4", oIFID_PC4, expIf.pc4);
        end
      end else begin
        chk("ifid_hold_valid", {31'b0, oIFID_Valid}, {31'b0, expValid});
        if (expValid) begin
          chk("ifid_hold_instr", oIFID_Instr, expIf.instr);
          chk("ifid_hold_pc4", oIFID_PC4, expIf.pc4);
        end
      end
      prevRedir = iRedirect;
      prevBlk = iBlockIFID;
    end
  end

  initial begin
    iRST = 1'b1;
    iBlockPC = 1'b0;
    iBlockIFID = 1'b0;
    iRedirect = 1'b0;
    iRedirectPC = '0;
    iIMemAck = 1'b0;
    iIMemData = '0;
    cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
    cyc(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1);
    chk("rst_req", {31'b0, oIMemReq}, 32'd0);
    chk("rst_addr", oIMemAddr, RST_PC);
    chk("rst_instr", oIFID_Instr, 32'd0);
    chk("rst_pc4", oIFID_PC4, 32'd0);
    chk("rst_valid", {31'b0, oIFID_Valid}, 32'd0);
    chk("rst_stall", oStallCount, 32'd0);

    // delayed ack: address stable while waiting, stall count tracks the wait
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait_addr", oIMemAddr, RST_PC);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("wait_addr", oIMemAddr, RST_PC);
    end
    cyc(1, 0, 0, 0, 0, 32'hA000_0001);
`ifdef FETCH_STALLCNT_EN
    chk("wait_stall", oStallCount, 32'd3);
`else
    chk("wait_stall", oStallCount, 32'd0);
`endif

    // reset release with ack tied high: back-to-back sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 32'h7777_0000);
    chk("seq_addr0", oIMemAddr, 32'h0040_0000);
    cyc(1, 0, 0, 0, 0, 32'h1111_0000);
    chk("seq_addr1", oIMemAddr, 32'h0040_0004);
    chk("seq_pc4", oIFID_PC4, 32'h0040_0004);
    chk("seq_valid", {31'b0, oIFID_Valid}, 32'd1);
    cyc(1, 0, 0, 0, 0, 32'h1111_0001);
    chk("seq_addr2", oIMemAddr, 32'h0040_0008);
    cyc(1, 0, 0, 0, 0, 32'h1111_0002);
    chk("seq_addr3", oIMemAddr, 32'h0040_000C);

    // blocked ack goes to HOLD, word released on first unblocked edge
    cyc(1, 1, 1, 0, 0, 32'h8C88_0004);
    chk("hold_instr0", oIFID_Instr, 32'h1111_0002);
    cyc(0, 1, 1, 0, 0, 0);
    chk("hold_instr1", oIFID_Instr, 32'h1111_0002);
    chk("hold_req", {31'b0, oIMemReq}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_release_instr", oIFID_Instr, 32'h8C88_0004);
    chk("hold_release_pc4", oIFID_PC4, 32'h0040_0010);
    chk("hold_next_addr", oIMemAddr, 32'h0040_0010);

    // redirect with coincident ack
    cyc(1, 0, 0, 1, 32'h0040_0100, 32'h0BAD_F00D);
    chk("redir_valid", {31'b0, oIFID_Valid}, 32'd0);
    chk("redir_instr", oIFID_Instr, 32'd0);
    chk("redir_addr", oIMemAddr, 32'h0040_0100);

    // redirect without ack: the late ack is discarded
    cyc(0, 0, 0, 1, 32'h0040_0200, 0);
    chk("discard_old_addr", oIMemAddr, 32'h0040_0100);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("discard_valid", {31'b0, oIFID_Valid}, 32'd0);
    chk("discard_new_addr", oIMemAddr, 32'h0040_0200);
    cyc(1, 0, 0, 0, 0, 32'h1234_5678);
    chk("discard_next_instr", oIFID_Instr, 32'h1234_5678);
    chk("discard_next_pc4", oIFID_PC4, 32'h0040_0204);

    // misaligned target and PC wrap
    cyc(1, 0, 0, 1, 32'h0040_0103, 0);
    chk("align_addr", oIMemAddr, 32'h0040_0100);
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_addr0", oIMemAddr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 32'h5A5A_5A5A);
    chk("wrap_addr1", oIMemAddr, 32'h0000_0000);
    chk("wrap_pc4", oIFID_PC4, 32'h0000_0000);
    chk("wrap_instr", oIFID_Instr, 32'h5A5A_5A5A);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, rd;
      r = ($urandom_range(0, 399) == 0);
      rd = !r && !mIdle && ($urandom_range(0, 11) == 0);
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          rd, $urandom, $urandom, r);
    end
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drain", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, which is the first fetch address after reset.
REQ-002 SHALL have port iCLK, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port iRST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port iBlockPC, input, 1 bit: hold the PC (hazard stall).
REQ-005 SHALL have port iBlockIFID, input, 1 bit: hold the IF/ID register (hazard stall).
REQ-006 SHALL have port iRedirect, input, 1 bit: a taken branch, jump or jr was resolved in ID.
REQ-007 SHALL have port iRedirectPC, input, 32 bits: the redirect target.
REQ-008 SHALL have port oIMemReq, output, 1 bit: instruction-memory request.
REQ-009 SHALL have port oIMemAddr, output, 32 bits: the fetch address.
REQ-010 SHALL have port iIMemAck, input, 1 bit: iIMemData is valid this cycle.
REQ-011 SHALL have port iIMemData, input, 32 bits: the fetched instruction.
REQ-012 SHALL have ports oIFID_Instr (output, 32 bits), oIFID_PC4 (output, 32 bits) and oIFID_Valid (output, 1 bit): the IF/ID register contents.
REQ-013 SHALL have port oStallCount, output, 32 bits: the fetch stall counter (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, HOLD and DISCARD.
REQ-015 IDLE SHALL move to FETCH unconditionally on the next edge, with oIMemReq=0 while in IDLE.
REQ-016 In FETCH, oIMemReq SHALL be 1 and oIMemAddr SHALL equal PC, held stable until iIMemAck.
REQ-017 On FETCH, ack=1, block=0, redirect=0: IF/ID SHALL load {iIMemData, PC+4, valid=1}, PC SHALL become PC+4, the FSM SHALL stay in FETCH, and the next request SHALL issue back-to-back.
REQ-018 On FETCH, ack=1, redirect=0, with iBlockPC or iBlockIFID asserted: iIMemData SHALL be captured in the hold register, the FSM SHALL go to HOLD, and both PC and IF/ID SHALL stay unchanged.
REQ-019 In HOLD, oIMemReq SHALL be 0; when both blocks are low, IF/ID SHALL load from the hold register, PC SHALL become PC+4, and the FSM SHALL go to FETCH.
REQ-020 Redirect in FETCH with ack=1, or in HOLD: the fetched or held word SHALL be dropped, PC SHALL become iRedirectPC, oIFID_Valid SHALL become 0, oIFID_Instr SHALL become 32'h0 (NOP), and the FSM SHALL go to FETCH.
REQ-021 Redirect in FETCH with ack=0: iRedirectPC SHALL be latched, IF/ID SHALL be invalidated, and the FSM SHALL go to DISCARD.
REQ-022 In DISCARD, oIMemReq SHALL stay 1 with the old address until ack; the acked data SHALL be dropped, PC SHALL become the latched target, and the FSM SHALL go to FETCH.
REQ-023 In DISCARD, a further redirect SHALL overwrite the latched target.
REQ-024 iRedirect SHALL take priority over iBlockPC and iBlockIFID.
REQ-025 With iBlockIFID=1 and no redirect, IF/ID SHALL hold its value, including Valid.
REQ-026 PC+4 SHALL wrap modulo 2^32.
REQ-027 iRedirectPC[1:0] SHALL be ignored, with PC[1:0] forced to 00.
REQ-028 Fetch latency SHALL be one cycle: ack in cycle N makes the word visible on the IF/ID outputs in cycle N+1.

Reset
REQ-029 While iRST=1: state SHALL be IDLE, PC SHALL be RESET_PC, oIMemReq SHALL be 0, oIMemAddr SHALL be RESET_PC, oIFID_Instr, oIFID_PC4 and oIFID_Valid SHALL be 0, the hold register SHALL be 0, and oStallCount SHALL be 0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; an ack arriving while the FSM is in IDLE SHALL be ignored.

Configuration
REQ-031 Macro FETCH_STALLCNT_EN defined: oStallCount SHALL increment once per cycle in which the FSM is in HOLD or DISCARD, or in FETCH with ack=0, or iBlockIFID=1, and SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Macro FETCH_STALLCNT_EN undefined: oStallCount SHALL be constant 0, with no counter logic.

Structure
REQ-033 Shared package mips_pipe_pkg SHALL hold the FSM state encoding, the RESET_PC default and the NOP constant (32'h0).
REQ-034 The hold register and its load/drop control SHALL be the sub-module fetch_skid_reg; the FSM, PC and IF/ID SHALL stay in fetch_unit.

Verification
REQ-035 Bench SHALL cover: reset release with ack tied to 1 -> addresses 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; oIFID_PC4=0x00400004 one cycle after the first ack.
REQ-036 Bench SHALL cover: ack delayed 3 cycles -> oIMemAddr stable for 4 cycles; oStallCount=3 (macro on).
REQ-037 Bench SHALL cover: iBlockPC=iBlockIFID=1 for 2 cycles coincident with an ack of 0x8C880004 -> HOLD; IF/ID unchanged; 0x8C880004 loads on the first unblocked edge; no refetch.
REQ-038 Bench SHALL cover: iRedirect with target 0x00400100 plus ack in the same cycle -> oIFID_Valid=0, instr=0; next oIMemAddr=0x00400100.
REQ-039 Bench SHALL cover: redirect to 0x00400200 while ack=0, then ack after 2 cycles -> that data is dropped; next request is to 0x00400200.
REQ-040 Bench SHALL cover: iRedirectPC=0x00400103 -> fetch from 0x00400100; PC 0xFFFFFFFC + ack -> next address 0x00000000.
